// File: rtl/box_filter_ctrl_if.sv
// Handshake bundle between the motion-pixel source, box_filter_ctrl and the 3x3 box filter.
// The slave side is the controller; the master side is its environment.
interface box_filter_ctrl_if;
  logic       start;
  logic [3:0] neighbors_cfg;
  logic       in_valid;
  logic       in_pixel;
  logic       in_ready;
  logic       box_en;
  logic [8:0] motion_map;
  logic [3:0] neighbors_number;
  logic       filtered_motion;
  logic       out_valid;
  logic       out_motion;
  logic       out_last;
  logic       frame_done;
  logic       busy;

  modport master (
    output start, neighbors_cfg, in_valid, in_pixel, filtered_motion,
    input  in_ready, box_en, motion_map, neighbors_number,
           out_valid, out_motion, out_last, frame_done, busy
  );

  modport slave (
    input  start, neighbors_cfg, in_valid, in_pixel, filtered_motion,
    output in_ready, box_en, motion_map, neighbors_number,
           out_valid, out_motion, out_last, frame_done, busy
  );
endinterface

// File: rtl/box_filter_ctrl.sv
// Frame sequencer for the 3x3 box filter: builds zero-padded neighbourhoods from a
// raster motion stream in a two-line shift buffer and frames the filter result.
module box_filter_ctrl #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 24
) (
  input  logic              clk,
  input  logic              rst,
  box_filter_ctrl_if.slave  bus
);

  localparam int TAPS = 2*IMG_W + 3;
  localparam int NPIX = IMG_W*IMG_H;
  localparam int NADV = NPIX + IMG_W + 1;
  localparam int CW   = $clog2(NADV + 1);
  localparam int RW   = $clog2(IMG_H);
  localparam int XW   = $clog2(IMG_W);

  localparam logic [CW-1:0] LAST_PIX  = CW'(NPIX - 1);
  localparam logic [CW-1:0] FIRST_WIN = CW'(IMG_W + 1);
  localparam logic [CW-1:0] LAST_ADV  = CW'(NADV - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [XW-1:0] COL_LAST  = XW'(IMG_W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]      state_reg, state_next;
  logic [CW-1:0]   adv_cnt_reg;
  logic [TAPS-1:0] taps_reg;
  logic [RW-1:0]   cen_row_reg;
  logic [XW-1:0]   cen_col_reg;
  logic [3:0]      nn_reg;
  logic            box_en_reg;
  logic            box_last_reg;
  logic            out_valid_reg;
  logic            out_last_reg;

  logic            accept;
  logic            advance;
  logic            shift_bit;
  logic            win;
  logic [8:0]      map_masked;

  assign accept    = (state_reg == S_RUN) && bus.in_valid;
  assign advance   = accept || (state_reg == S_FLUSH);
  assign shift_bit = (state_reg == S_RUN) ? bus.in_pixel : 1'b0;
  // The first IMG_W+1 advances only prime the buffer; later ones each complete a window.
  assign win       = advance && (adv_cnt_reg >= FIRST_WIN);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (bus.start) state_next = S_RUN;
      S_RUN:   if (accept && adv_cnt_reg == LAST_PIX) state_next = S_FLUSH;
      S_FLUSH: if (adv_cnt_reg == LAST_ADV) state_next = S_DRAIN;
      S_DRAIN: if (out_last_reg) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      adv_cnt_reg   <= '0;
      taps_reg      <= '0;
      cen_row_reg   <= '0;
      cen_col_reg   <= '0;
      nn_reg        <= '0;
      box_en_reg    <= 1'b0;
      box_last_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      box_en_reg    <= win;
      box_last_reg  <= advance && (adv_cnt_reg == LAST_ADV);
      out_valid_reg <= box_en_reg;
      out_last_reg  <= box_last_reg;

      if (state_reg == S_IDLE && bus.start) begin
        nn_reg      <= bus.neighbors_cfg;
        adv_cnt_reg <= '0;
        taps_reg    <= '0;
        cen_row_reg <= '0;
        cen_col_reg <= '0;
      end else if (advance) begin
        taps_reg    <= {taps_reg[TAPS-2:0], shift_bit};
        adv_cnt_reg <= adv_cnt_reg + 1'b1;
        if (win) begin
          if (adv_cnt_reg == FIRST_WIN) begin
            cen_row_reg <= '0;
            cen_col_reg <= '0;
          end else if (cen_col_reg == COL_LAST) begin
            cen_col_reg <= '0;
            cen_row_reg <= cen_row_reg + 1'b1;
          end else begin
            cen_col_reg <= cen_col_reg + 1'b1;
          end
        end
      end
    end
  end

  // Map bit 3*dr+dc picks tap (2-dr)*IMG_W+(2-dc); border rows/columns are forced to 0,
  // which also keeps the previous row's tail and the flush zeros out of the window.
  genvar gi, gj;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_row
      for (gj = 0; gj < 3; gj++) begin : g_col
        logic row_ok;
        logic col_ok;
        if (gi == 0) begin : g_top
          assign row_ok = (cen_row_reg != '0);
        end else if (gi == 2) begin : g_bot
          assign row_ok = (cen_row_reg != ROW_LAST);
        end else begin : g_mid
          assign row_ok = 1'b1;
        end
        if (gj == 0) begin : g_left
          assign col_ok = (cen_col_reg != '0);
        end else if (gj == 2) begin : g_right
          assign col_ok = (cen_col_reg != COL_LAST);
        end else begin : g_ctr
          assign col_ok = 1'b1;
        end
        assign map_masked[3*gi+gj] = taps_reg[(2-gi)*IMG_W + (2-gj)] & row_ok & col_ok;
      end
    end
  endgenerate

  assign bus.in_ready         = (state_reg == S_RUN);
  assign bus.busy             = (state_reg != S_IDLE);
  assign bus.box_en           = box_en_reg;
  assign bus.motion_map       = box_en_reg ? map_masked : 9'd0;
  assign bus.neighbors_number = nn_reg;
  assign bus.out_valid        = out_valid_reg;
  assign bus.out_motion       = out_valid_reg & bus.filtered_motion;
  assign bus.out_last         = out_last_reg;
  assign bus.frame_done       = out_last_reg;

endmodule
